crg_clk_gate_ctrl: RTL and testbench

- Sequencer that drives the enable and test-enable inputs of a CRG clock-gate cell for one gated clock domain.
- Detects sustained idleness and runs a request/acknowledge handshake with the domain before stopping its clock.
- Restores the clock on wake with a programmable settle delay before releasing the handshake.
- Sits in the CRG next to the clock-gate cell; all inputs are already synchronous to clk.

---
 rtl/crg_clk_gate_ctrl.sv | 139 +++++++++++++
 tb/tb_crg_clk_gate_ctrl.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crg_clk_gate_ctrl.sv
// crg_clk_gate_ctrl: idle-detect and handshake sequencer for one
// CRG clock-gate cell (enable + test-enable) of a gated clock domain.
module crg_clk_gate_ctrl #(
    parameter int CNT_W    = 8,
    parameter int WAKE_DLY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gate_allow,
    input  logic             force_on,
    input  logic             idle,
    input  logic [CNT_W-1:0] idle_thresh,
    input  logic             wake_req,
    input  logic             off_ack,
    input  logic             off_deny,
    input  logic             test_en,
    output logic             cg_en,
    output logic             cg_ten,
    output logic             off_req,
    output logic             gated
);

    localparam int             WW      = $clog2(WAKE_DLY + 1);
    localparam logic [WW-1:0]  WLIM    = WW'(WAKE_DLY);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WW-1:0]  W_ONE   = WW'(1);

    typedef enum logic [2:0] {
        S_RUN,
        S_COUNT,
        S_REQ,
        S_GATED,
        S_WAKE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [WW-1:0]    wcnt;
    logic [WW-1:0]    wcnt_nx;
    logic             cg_en_nx;
    logic             off_req_nx;
    logic             gated_nx;
    logic             go_idle;
    logic             wake;
    logic             thr_hit;

    assign cg_ten  = test_en;
    assign go_idle = gate_allow & ~force_on & idle;
    assign wake    = wake_req | force_on | ~gate_allow;
    // cnt starts at 1 in COUNT, so a threshold of 0 acts like 1
    assign thr_hit = (cnt >= idle_thresh);

    // Next-state, counters and decoded outputs for the next cycle
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wcnt_nx  = wcnt;
        case (state)
            S_RUN: begin
                cnt_nx = '0;
                if (go_idle) begin
                    state_nx = S_COUNT;
                    cnt_nx   = CNT_ONE;
                end
            end
            S_COUNT: begin
                if (!go_idle) begin
                    state_nx = S_RUN;
                    cnt_nx   = '0;
                end else if (thr_hit && !off_ack) begin
                    // an ack still high from a previous request holds us
                    // here so off_req cannot re-assert before it drops
                    state_nx = S_REQ;
                    cnt_nx   = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            S_REQ: begin
                if (off_deny) begin
                    state_nx = S_RUN;
                end else if (wake || !idle) begin
                    state_nx = S_RUN;
                end else if (off_ack) begin
                    state_nx = S_GATED;
                end
            end
            S_GATED: begin
                // idle is stale while the clock is stopped
                if (wake) begin
                    state_nx = S_WAKE;
                    wcnt_nx  = '0;
                end
            end
            S_WAKE: begin
                if (wcnt < WLIM) begin
                    wcnt_nx = wcnt + W_ONE;
                end else if (!off_ack) begin
                    state_nx = S_RUN;
                    wcnt_nx  = '0;
                end
            end
            default: begin
                state_nx = S_RUN;
                cnt_nx   = '0;
                wcnt_nx  = '0;
            end
        endcase

        cg_en_nx   = (state_nx != S_GATED);
        gated_nx   = (state_nx == S_GATED);
        off_req_nx = (state_nx == S_REQ)
                   | (state_nx == S_GATED)
                   | ((state_nx == S_WAKE) && (wcnt_nx < WLIM));
    end

    // State, counters and registered outputs; reset restores the clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_RUN;
            cnt     <= '0;
            wcnt    <= '0;
            cg_en   <= 1'b1;
            off_req <= 1'b0;
            gated   <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            wcnt    <= wcnt_nx;
            cg_en   <= cg_en_nx;
            off_req <= off_req_nx;
            gated   <= gated_nx;
        end
    end

endmodule

// File: tb/tb_crg_clk_gate_ctrl.sv
// tb_crg_clk_gate_ctrl: directed scenarios plus randomized traffic
// checked against a phase-level reference model of the gate sequencer.
module tb_crg_clk_gate_ctrl;

    localparam int CNT_W    = 8;
    localparam int WAKE_DLY = 2;
    localparam int RUN_MAX  = (1 << CNT_W) - 1;

    localparam int PH_AWAKE = 0;
    localparam int PH_REQ   = 1;
    localparam int PH_OFF   = 2;
    localparam int PH_WAKE  = 3;

    logic             clk;
    logic             rst;
    logic             gate_allow;
    logic             force_on;
    logic             idle;
    logic [CNT_W-1:0] idle_thresh;
    logic             wake_req;
    logic             off_ack;
    logic             off_deny;
    logic             test_en;
    logic             cg_en;
    logic             cg_ten;
    logic             off_req;
    logic             gated;

    int errors;
    int checks;

    int m_ph;
    int m_run;
    int m_set;

    crg_clk_gate_ctrl #(
        .CNT_W(CNT_W),
        .WAKE_DLY(WAKE_DLY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .gate_allow(gate_allow),
        .force_on(force_on),
        .idle(idle),
        .idle_thresh(idle_thresh),
        .wake_req(wake_req),
        .off_ack(off_ack),
        .off_deny(off_deny),
        .test_en(test_en),
        .cg_en(cg_en),
        .cg_ten(cg_ten),
        .off_req(off_req),
        .gated(gated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_cg_en();
        return (m_ph != PH_OFF);
    endfunction

    function automatic logic exp_gated();
        return (m_ph == PH_OFF);
    endfunction

    function automatic logic exp_off_req();
        return (m_ph == PH_REQ) || (m_ph == PH_OFF) ||
               ((m_ph == PH_WAKE) && (m_set < WAKE_DLY));
    endfunction

    // advance the reference by one clock using the inputs now applied
    task automatic model_step();
        bit gi;
        bit wk;
        int th;
        gi = gate_allow && !force_on && idle;
        wk = wake_req || force_on || !gate_allow;
        th = (idle_thresh == 0) ? 1 : int'(idle_thresh);
        case (m_ph)
            PH_AWAKE: begin
                if (!gi) m_run = 0;
                else if (m_run >= th && !off_ack) begin
                    m_ph  = PH_REQ;
                    m_run = 0;
                end else if (m_run < RUN_MAX) m_run++;
            end
            PH_REQ: begin
                if (off_deny || wk || !idle) m_ph = PH_AWAKE;
                else if (off_ack) m_ph = PH_OFF;
            end
            PH_OFF: begin
                if (wk) begin
                    m_ph  = PH_WAKE;
                    m_set = 0;
                end
            end
            default: begin
                if (m_set < WAKE_DLY) m_set++;
                else if (!off_ack) begin
                    m_ph  = PH_AWAKE;
                    m_run = 0;
                end
            end
        endcase
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst         = 1'b1;
        gate_allow  = 1'b0;
        force_on    = 1'b0;
        idle        = 1'b0;
        idle_thresh = '0;
        wake_req    = 1'b0;
        off_ack     = 1'b0;
        off_deny    = 1'b0;
        test_en     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        m_ph  = PH_AWAKE;
        m_run = 0;
        m_set = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (cg_en !== 1'b1 || off_req !== 1'b0 || gated !== 1'b0) begin
            errors++;
            $display("FAIL reset cg_en/off_req/gated=%b%b%b exp=100",
                     cg_en, off_req, gated);
        end
        idle = 1'b1;
        repeat (3) tick();
        checks++;
        if (cg_en !== 1'b1 || off_req !== 1'b0) begin
            errors++;
            $display("FAIL no_allow cg_en/off_req=%b%b exp=10",
                     cg_en, off_req);
        end
    endtask

    task automatic test_gate_and_wake();
        apply_reset();
        gate_allow  = 1'b1;
        idle        = 1'b1;
        idle_thresh = 8'd4;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (off_req !== 1'b0 || cg_en !== 1'b1) begin
                errors++;
                $display("FAIL count%0d off_req=%b cg_en=%b exp=0,1",
                         i, off_req, cg_en);
            end
        end
        tick();
        checks++;
        if (off_req !== 1'b1) begin
            errors++;
            $display("FAIL req_rise off_req=%b exp=1", off_req);
        end
        tick();
        off_ack = 1'b1;
        tick();
        checks++;
        if (cg_en !== 1'b0 || gated !== 1'b1 || off_req !== 1'b1) begin
            errors++;
            $display("FAIL gated cg_en/gated/off_req=%b%b%b exp=011",
                     cg_en, gated, off_req);
        end
        idle = 1'b0;
        tick();
        checks++;
        if (cg_en !== 1'b0 || gated !== 1'b1) begin
            errors++;
            $display("FAIL stale_idle cg_en/gated=%b%b exp=01",
                     cg_en, gated);
        end
        wake_req = 1'b1;
        tick();
        wake_req = 1'b0;
        checks++;
        if (cg_en !== 1'b1 || gated !== 1'b0 || off_req !== 1'b1) begin
            errors++;
            $display("FAIL wake cg_en/gated/off_req=%b%b%b exp=101",
                     cg_en, gated, off_req);
        end
        for (int i = 1; i < WAKE_DLY; i++) begin
            tick();
            checks++;
            if (off_req !== 1'b1) begin
                errors++;
                $display("FAIL settle%0d off_req=%b exp=1", i, off_req);
            end
        end
        tick();
        checks++;
        if (off_req !== 1'b0 || cg_en !== 1'b1) begin
            errors++;
            $display("FAIL release off_req=%b cg_en=%b exp=0,1",
                     off_req, cg_en);
        end
        tick();
        off_ack     = 1'b0;
        idle_thresh = 8'd0;
        idle        = 1'b1;
        tick();
        tick();
        checks++;
        if (off_req !== 1'b0) begin
            errors++;
            $display("FAIL back_run off_req=%b exp=0", off_req);
        end
        tick();
        checks++;
        if (off_req !== 1'b1 || gated !== 1'b0) begin
            errors++;
            $display("FAIL regate off_req=%b gated=%b exp=1,0",
                     off_req, gated);
        end
    endtask

    task automatic test_short_idle();
        apply_reset();
        gate_allow  = 1'b1;
        idle_thresh = 8'd4;
        idle        = 1'b1;
        repeat (3) tick();
        idle = 1'b0;
        tick();
        checks++;
        if (off_req !== 1'b0 || cg_en !== 1'b1) begin
            errors++;
            $display("FAIL short_idle off_req=%b cg_en=%b exp=0,1",
                     off_req, cg_en);
        end
        idle = 1'b1;
        repeat (4) tick();
        checks++;
        if (off_req !== 1'b0) begin
            errors++;
            $display("FAIL cnt_cleared off_req=%b exp=0", off_req);
        end
        tick();
        checks++;
        if (off_req !== 1'b1) begin
            errors++;
            $display("FAIL recount off_req=%b exp=1", off_req);
        end
    endtask

    task automatic test_deny();
        apply_reset();
        gate_allow = 1'b1;
        idle       = 1'b1;
        tick();
        checks++;
        if (off_req !== 1'b0) begin
            errors++;
            $display("FAIL thresh0_early off_req=%b exp=0", off_req);
        end
        tick();
        checks++;
        if (off_req !== 1'b1) begin
            errors++;
            $display("FAIL thresh0_req off_req=%b exp=1", off_req);
        end
        off_deny = 1'b1;
        off_ack  = 1'b1;
        tick();
        off_deny = 1'b0;
        off_ack  = 1'b0;
        idle     = 1'b0;
        checks++;
        if (off_req !== 1'b0 || cg_en !== 1'b1 || gated !== 1'b0) begin
            errors++;
            $display("FAIL deny off_req/cg_en/gated=%b%b%b exp=010",
                     off_req, cg_en, gated);
        end
    endtask

    task automatic test_force();
        for (int k = 0; k < 3; k++) begin
            apply_reset();
            gate_allow  = 1'b1;
            idle        = 1'b1;
            idle_thresh = (k == 0) ? 8'd4 : 8'd0;
            tick();
            if (k > 0) tick();
            if (k == 2) begin
                off_ack = 1'b1;
                tick();
                checks++;
                if (cg_en !== 1'b0) begin
                    errors++;
                    $display("FAIL force_pre cg_en=%b exp=0", cg_en);
                end
            end
            force_on = 1'b1;
            tick();
            checks++;
            if (cg_en !== 1'b1 || gated !== 1'b0 ||
                off_req !== (k == 2)) begin
                errors++;
                $display("FAIL force%0d cg_en/gated/off_req=%b%b%b", k,
                         cg_en, gated, off_req);
            end
            force_on = 1'b0;
            off_ack  = 1'b0;
            gate_allow = 1'b0;
        end
    endtask

    task automatic test_thresh_change();
        apply_reset();
        gate_allow  = 1'b1;
        idle        = 1'b1;
        idle_thresh = 8'd10;
        repeat (2) tick();
        checks++;
        if (off_req !== 1'b0) begin
            errors++;
            $display("FAIL thr_high off_req=%b exp=0", off_req);
        end
        idle_thresh = 8'd1;
        tick();
        checks++;
        if (off_req !== 1'b1) begin
            errors++;
            $display("FAIL thr_drop off_req=%b exp=1", off_req);
        end
    endtask

    task automatic test_ack_hold();
        apply_reset();
        gate_allow = 1'b1;
        idle       = 1'b1;
        repeat (2) tick();
        off_ack  = 1'b1;
        wake_req = 1'b1;
        tick();
        wake_req = 1'b0;
        checks++;
        if (off_req !== 1'b0) begin
            errors++;
            $display("FAIL abort off_req=%b exp=0", off_req);
        end
        repeat (4) tick();
        checks++;
        if (off_req !== 1'b0) begin
            errors++;
            $display("FAIL ack_hold off_req=%b exp=0", off_req);
        end
        off_ack = 1'b0;
        tick();
        checks++;
        if (off_req !== 1'b1) begin
            errors++;
            $display("FAIL ack_free off_req=%b exp=1", off_req);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        test_en    = 1'b1;
        gate_allow = 1'b1;
        idle       = 1'b1;
        repeat (2) tick();
        off_ack = 1'b1;
        tick();
        checks++;
        if (cg_en !== 1'b0 || cg_ten !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst cg_en=%b cg_ten=%b exp=0,1",
                     cg_en, cg_ten);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (cg_en !== 1'b1 || off_req !== 1'b0 || gated !== 1'b0 ||
            cg_ten !== 1'b1) begin
            errors++;
            $display("FAIL async_rst cg_en/off_req/gated/cg_ten=%b%b%b%b",
                     cg_en, off_req, gated, cg_ten);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cg_en !== 1'b1 || cg_ten !== 1'b1) begin
            errors++;
            $display("FAIL rst_hold cg_en=%b cg_ten=%b exp=1,1",
                     cg_en, cg_ten);
        end
        off_ack    = 1'b0;
        gate_allow = 1'b0;
        rst        = 1'b0;
        m_ph       = PH_AWAKE;
        m_run      = 0;
        m_set      = 0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            gate_allow = ($urandom_range(0, 19) != 0);
            force_on   = ($urandom_range(0, 39) == 0);
            idle       = ($urandom_range(0, 9) != 0);
            wake_req   = ($urandom_range(0, 14) == 0);
            off_deny   = ($urandom_range(0, 24) == 0);
            test_en    = 1'($urandom);
            if ($urandom_range(0, 49) == 0)
                idle_thresh = 8'($urandom_range(0, 6));
            if (exp_off_req()) off_ack = ($urandom_range(0, 3) != 0);
            else               off_ack = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if (cg_en !== exp_cg_en() || off_req !== exp_off_req() ||
                gated !== exp_gated() || cg_ten !== test_en) begin
                errors++;
                $display("FAIL rand%0d got=%b%b%b%b exp=%b%b%b%b", c,
                         cg_en, off_req, gated, cg_ten,
                         exp_cg_en(), exp_off_req(), exp_gated(), test_en);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_gate_and_wake();
        test_short_idle();
        test_deny();
        test_force();
        test_thresh_change();
        test_ack_hold();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
